bcd_subtractor_serial: RTL and testbench
========================================

// Module: bcd_subtractor_serial
// PURPOSE
//  Digit-serial BCD subtractor: computes A - B - BIN over DIGITS packed BCD digits,
//  one digit per clock, least significant digit first, with a borrow register.
//  Start/done handshake; companion to the combinational BCD adder chain, used by
//  the datapath when area matters more than latency (e.g. counter/display decrement).
// PARAMETERS
//  DIGITS  3  number of BCD digits in each operand (>= 1)
// PORTS
//  clk      in   1           clock, all state changes on rising edge
//  rst      in   1           asynchronous, active-high reset
//  start    in   1           request; sampled only when busy = 0
//  a        in   4*DIGITS    minuend, packed BCD, digit k = a[4k+3:4k]
//  b        in   4*DIGITS    subtrahend, packed BCD
//  bin      in   1           borrow-in to least significant digit
//  d        out  4*DIGITS    difference, packed BCD (10's complement if bout = 1)
//  bout     out  1           borrow out of most significant digit
//  invalid  out  1           some digit of latched a or b was > 9
//  busy     out  1           operation in progress
//  done     out  1           one-cycle pulse: d/bout/invalid just updated
// BEHAVIOUR
//  Reset: state IDLE; d = 0, bout = 0, invalid = 0, busy = 0, done = 0,
//   internal operand/borrow/counter registers = 0. Reset mid-operation aborts it;
//   no done pulse is produced for the aborted operation.
//  FSM: IDLE -> RUN on start = 1; RUN -> IDLE after digit DIGITS-1 is processed.
//  IDLE edge with start = 1: latch a, b; borrow reg <= bin; digit counter <= 0;
//   invalid_acc <= 0; busy <= 1. start = 0: nothing changes, done <= 0.
//  RUN edge, digit k = counter:
//   t[4:0] = {1'b0,a_k} - {1'b0,b_k} - borrow (5-bit two's complement)
//   t[4] = 1: digit_k = t[3:0] + 10 (mod 16), borrow <= 1
//   t[4] = 0: digit_k = t[3:0], borrow <= 0
//   invalid_acc |= (a_k > 9) | (b_k > 9); digit_k stored in internal result reg;
//   counter increments. Formula applies unchanged to non-BCD digits.
//  Final RUN edge (k = DIGITS-1): d <= full result, bout <= borrow out of this
//   digit, invalid <= accumulated flag, busy <= 0, done <= 1, state <= IDLE.
//  Latency: start sampled at edge E0; done high in the cycle after edge E(DIGITS);
//   busy high from after E0 through E(DIGITS). Throughput one op per DIGITS+1 cycles.
//  start while busy = 1 is ignored (not queued). start at the same edge done is
//   asserted is not possible (busy still 1); start during the done cycle is accepted.
//  d, bout, invalid hold their values until the next completion or reset;
//   they never change while busy = 1.
//  Changes on a/b/bin after the start edge have no effect on the operation.
//  Result: bout = 0 -> d = A - B - BIN; bout = 1 -> d = 10^DIGITS + A - B - BIN.
// TESTING
//  1. a=0x225, b=0x100, bin=0, start pulse -> done after 3 cycles, d=0x125, bout=0, invalid=0.
//  2. a=0x100, b=0x225, bin=0 -> d=0x875, bout=1 (10's complement of 125).
//  3. a=0x000, b=0x000, bin=1 -> d=0x999, bout=1; a=0x999, b=0x999, bin=0 -> d=0x000, bout=0.
//  4. a=0x00A, b=0x001, bin=0 -> invalid=1, d=0x009, bout=0; next valid op clears invalid.
//  5. start re-asserted every cycle during op 1 with a=0x555 -> ignored, d=0x125; done
//     pulses once; new op accepted only in the done cycle or later.
//  6. rst asserted after first RUN edge of a=0x900, b=0x001 -> all outputs 0 at once,
//     busy=0, no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial BCD subtractor: A - B - BIN over DIGITS packed BCD digits, one
// digit per clock, least significant digit first, with a start/done handshake.
module bcd_subtractor_serial #(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic [4*DIGITS-1:0] d,
  output logic                bout,
  output logic                invalid,
  output logic                busy,
  output logic                done
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  // Handshake: start is taken only while busy is low. busy stays high from the
  // start edge through the final digit edge, and done pulses for one cycle
  // exactly when d/bout/invalid have just been updated.
  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          borrow_q, borrow_d, inv_q, inv_d;
  logic          bout_q, bout_d, invalid_q, invalid_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [3:0]    a_k, b_k, digit;
  logic [4:0]    t;
  logic [W-1:0]  digit_ext;

  // Operands shift right each RUN cycle, so the active digit is always at [3:0]
  // and the result fills in from the top.
  always_comb begin
    a_k       = a_q[3:0];
    b_k       = b_q[3:0];
    t         = {1'b0, a_k} - {1'b0, b_k} - {4'b0000, borrow_q};
    digit     = t[4] ? (t[3:0] + 4'd10) : t[3:0];
    digit_ext = W'(digit);
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    borrow_d  = borrow_q;
    inv_d     = inv_q;
    bout_d    = bout_q;
    invalid_d = invalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          inv_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        res_d    = (res_q >> 4) | (digit_ext << (W - 4));
        borrow_d = t[4];
        inv_d    = inv_q | (a_k > 4'd9) | (b_k > 4'd9);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d   = IDLE;
          d_d       = res_d;
          bout_d    = t[4];
          invalid_d = inv_d;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cnt_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      borrow_q  <= 1'b0;
      inv_q     <= 1'b0;
      bout_q    <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      borrow_q  <= borrow_d;
      inv_q     <= inv_d;
      bout_q    <= bout_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign d       = d_q;
  assign bout    = bout_q;
  assign invalid = invalid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Directed and random checks of the digit-serial BCD subtractor against a
// decimal reference model, with results matched through an expected queue.
module tb_bcd_subtractor_serial;

  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic [W-1:0] d;
  logic         bout, invalid, busy, done;

  logic [W+1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .d(d), .bout(bout), .invalid(invalid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Decimal reference: {invalid, bout, d} for valid BCD operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic bi);
    int x = 0, y = 0, p = 1, modv = 1, df;
    logic [W-1:0] r = '0;
    logic bo = 1'b0;
    logic [W-1:0] tmp_a = av, tmp_b = bv;
    for (int k = 0; k < DIGITS; k++) begin
      x += int'(tmp_a[3:0]) * p;
      y += int'(tmp_b[3:0]) * p;
      tmp_a = tmp_a >> 4;
      tmp_b = tmp_b >> 4;
      p *= 10;
    end
    modv = p;
    df = x - y - int'(bi);
    if (df < 0) begin
      df += modv;
      bo = 1'b1;
    end
    for (int k = 0; k < DIGITS; k++) begin
      r = r | (W'(df % 10) << (4 * k));
      df = df / 10;
    end
    return {1'b0, bo, r};
  endfunction

  // Drives one start pulse; leaves the bench at 1 time unit after the start edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          input bit push, input logic [W+1:0] exp);
    a = av; b = bv; bin = bi; start = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("done_low_after_start", 32'(done), 32'd0);
  endtask

  // Waits for done (bounded), checks latency and pops the scoreboard.
  task automatic wait_done(input string tag);
    int cyc = 0;
    bit got = 0;
    logic [W+1:0] e;
    while (cyc < 10 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(DIGITS));
    if (got) begin
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected_done"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_d"}, 32'(d), 32'(e[W-1:0]));
        check({tag, "_bout"}, 32'(bout), 32'(e[W]));
        check({tag, "_invalid"}, 32'(invalid), 32'(e[W+1]));
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic rbi;
    bit saw_done;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_d", 32'(d), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    start_op(12'h225, 12'h100, 1'b0, 1, {2'b00, 12'h125});
    wait_done("t1");

    start_op(12'h100, 12'h225, 1'b0, 1, {2'b01, 12'h875});
    check("hold_d_while_busy", 32'(d), 32'h125);
    wait_done("t2");

    start_op(12'h000, 12'h000, 1'b1, 1, {2'b01, 12'h999});
    wait_done("t3a");
    start_op(12'h999, 12'h999, 1'b0, 1, {2'b00, 12'h000});
    wait_done("t3b");

    start_op(12'h00A, 12'h001, 1'b0, 1, {2'b10, 12'h009});
    wait_done("t4_invalid");
    start_op(12'h050, 12'h049, 1'b0, 1, model(12'h050, 12'h049, 1'b0));
    wait_done("t4_clear");

    // start held high through the op with new operands: ignored until done cycle
    start_op(12'h225, 12'h100, 1'b0, 1, {2'b00, 12'h125});
    a = 12'h555; b = 12'h000; bin = 1'b0; start = 1'b1;
    wait_done("t5_first");
    exp_q.push_back(model(12'h555, 12'h000, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    check("t5_accept_in_done_cycle", 32'(busy), 32'd1);
    check("t5_done_single_pulse", 32'(done), 32'd0);
    wait_done("t5_second");

    // Reset mid-operation
    start_op(12'h900, 12'h001, 1'b0, 0, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t6_d_zero", 32'(d), 32'd0);
    check("t6_bout_zero", 32'(bout), 32'd0);
    check("t6_busy_zero", 32'(busy), 32'd0);
    check("t6_done_zero", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_done = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    check("t6_no_done_after_abort", 32'(saw_done), 32'd0);
    start_op(12'h900, 12'h001, 1'b0, 1, {2'b00, 12'h899});
    wait_done("t6_after");

    // Random valid BCD operands
    for (int i = 0; i < 8; i++) begin
      ra = '0; rb = '0;
      for (int k = 0; k < DIGITS; k++) begin
        ra = ra | (W'($urandom_range(9, 0)) << (4 * k));
        rb = rb | (W'($urandom_range(9, 0)) << (4 * k));
      end
      rbi = 1'($urandom_range(1, 0));
      start_op(ra, rb, rbi, 1, model(ra, rb, rbi));
      wait_done("rand");
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
